// File: rtl/status_cond_unit.sv
// status_cond_unit: NZCV status register, per-lane condition evaluation, saturating exec/skip counters.
// Latency: 1 cycle from accept to pass_valid/pass; one lane group accepted per cycle.
// Backpressure: cond_ready drops in flag-write cycles unless COND_BYPASS_EN forwards flag_in (ready tied high).
module status_cond_unit #(
  parameter int LANES = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flag_we,
  input  logic [3:0]           flag_in,
  input  logic                 flush,
  input  logic [LANES-1:0]     cond_valid,
  input  logic [4*LANES-1:0]   cond,
  output logic                 cond_ready,
  output logic [LANES-1:0]     pass_valid,
  output logic [LANES-1:0]     pass,
  output logic [3:0]           status,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     cnt_exec,
  output logic [CNT_W-1:0]     cnt_skip
);

  logic [3:0]       status_q, status_d;
  logic [LANES-1:0] pv_q, pv_d;
  logic [LANES-1:0] pass_q, pass_d;
  logic [LANES-1:0] accept;
  logic [CNT_W-1:0] exec_q, exec_d;
  logic [CNT_W-1:0] skip_q, skip_d;
  logic [CNT_W:0]   exec_inc, skip_inc;
  logic [CNT_W:0]   exec_sum, skip_sum;
  logic [3:0]       eval_flags;

  function automatic logic cond_eval(input logic [3:0] code, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    cond_eval = 1'b0;
    case (code)
      4'h0: cond_eval = z;
      4'h1: cond_eval = ~z;
      4'h2: cond_eval = c;
      4'h3: cond_eval = ~c;
      4'h4: cond_eval = n;
      4'h5: cond_eval = ~n;
      4'h6: cond_eval = v;
      4'h7: cond_eval = ~v;
      4'h8: cond_eval = c & ~z;
      4'h9: cond_eval = ~c | z;
      4'hA: cond_eval = (n == v);
      4'hB: cond_eval = (n != v);
      4'hC: cond_eval = ~z & (n == v);
      4'hD: cond_eval = z | (n != v);
      4'hE: cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

`ifdef COND_BYPASS_EN
  // The ALU write is forwarded so a dependent condition never stalls.
  assign cond_ready = 1'b1;
  assign eval_flags = flag_we ? flag_in : status_q;
`else
  // Requester holds through the write cycle and sees the updated register next cycle.
  assign cond_ready = ~flag_we;
  assign eval_flags = status_q;
`endif

  always_comb begin
    status_d = flag_we ? flag_in : status_q;
    accept   = '0;
    pv_d     = '0;
    pass_d   = '0;
    exec_inc = '0;
    skip_inc = '0;
    for (int i = 0; i < LANES; i++) begin
      accept[i] = cond_valid[i] & cond_ready & ~flush;
      pv_d[i]   = accept[i];
      pass_d[i] = accept[i] & cond_eval(cond[4*i +: 4], eval_flags);
      if (accept[i]) begin
        if (pass_d[i]) exec_inc = exec_inc + (CNT_W+1)'(1);
        else           skip_inc = skip_inc + (CNT_W+1)'(1);
      end
    end
    // The extra carry bit flags overflow so the counters stick at all-ones.
    exec_sum = {1'b0, exec_q} + exec_inc;
    skip_sum = {1'b0, skip_q} + skip_inc;
    if (cnt_clr)             exec_d = '0;
    else if (exec_sum[CNT_W]) exec_d = '1;
    else                     exec_d = exec_sum[CNT_W-1:0];
    if (cnt_clr)             skip_d = '0;
    else if (skip_sum[CNT_W]) skip_d = '1;
    else                     skip_d = skip_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
      pv_q     <= '0;
      pass_q   <= '0;
      exec_q   <= '0;
      skip_q   <= '0;
    end else begin
      status_q <= status_d;
      pv_q     <= pv_d;
      pass_q   <= pass_d;
      exec_q   <= exec_d;
      skip_q   <= skip_d;
    end
  end

  assign status     = status_q;
  assign pass_valid = pv_q;
  assign pass       = pass_q;
  assign cnt_exec   = exec_q;
  assign cnt_skip   = skip_q;

endmodule

// File: tb/tb_status_cond_unit.sv
// Scoreboard bench for status_cond_unit: expected {pass_valid,pass,cnt_exec,cnt_skip,status} queued at drive time.
module tb_status_cond_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flag_we;
  logic [3:0]  flag_in;
  logic        flush;
  logic [1:0]  cond_valid;
  logic [7:0]  cond;
  logic        cond_ready;
  logic [1:0]  pass_valid;
  logic [1:0]  pass;
  logic [3:0]  status;
  logic        cnt_clr;
  logic [15:0] cnt_exec;
  logic [15:0] cnt_skip;

  int checks = 0;
  int errors = 0;

  logic [3:0]  mflags;
  int          mexec;
  int          mskip;
  logic [39:0] exp_q[$];
  logic [39:0] exp_v;

  status_cond_unit #(.LANES(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .flag_in(flag_in), .flush(flush),
    .cond_valid(cond_valid), .cond(cond), .cond_ready(cond_ready),
    .pass_valid(pass_valid), .pass(pass), .status(status), .cnt_clr(cnt_clr),
    .cnt_exec(cnt_exec), .cnt_skip(cnt_skip)
  );

  always #5 clk = ~clk;

  function automatic logic ref_cond(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (code)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Drives one cycle of stimulus at the falling edge and queues the post-edge expectation.
  task automatic drive_group(input logic we, input logic [3:0] fin, input logic fl,
                             input logic clr, input logic [1:0] vld, input logic [7:0] cd);
    logic       rdy;
    logic [3:0] f;
    logic [1:0] acc, p;
    int         ne, ns;
    @(negedge clk);
    flag_we = we; flag_in = fin; flush = fl; cnt_clr = clr; cond_valid = vld; cond = cd;
`ifdef COND_BYPASS_EN
    rdy = 1'b1;
    f   = we ? fin : mflags;
`else
    rdy = !we;
    f   = mflags;
`endif
    ne = 0; ns = 0;
    for (int i = 0; i < 2; i++) begin
      acc[i] = vld[i] && rdy && !fl;
      p[i]   = acc[i] && ref_cond(cd[4*i +: 4], f);
      if (acc[i]) begin
        if (p[i]) ne++;
        else      ns++;
      end
    end
    if (clr) begin
      mexec = 0; mskip = 0;
    end else begin
      mexec = (mexec + ne > 65535) ? 65535 : mexec + ne;
      mskip = (mskip + ns > 65535) ? 65535 : mskip + ns;
    end
    if (we) mflags = fin;
    exp_q.push_back({acc, p, mexec[15:0], mskip[15:0], mflags});
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flag_we = 1'b0; flag_in = 4'h0; flush = 1'b0; cnt_clr = 1'b0;
    cond_valid = 2'b00; cond = 8'h00;
    mflags = 4'h0; mexec = 0; mskip = 0; exp_q.delete();
    #12;
    checks++;
    if ({pass_valid, pass, cnt_exec, cnt_skip, status} !== 40'h0) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", {pass_valid, pass, cnt_exec, cnt_skip, status}, 40'h0);
    end
    checks++;
    if (cond_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", cond_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    drive_group(1'b1, 4'b0100, 1'b0, 1'b0, 2'b00, 8'h00);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    checks++;
    if ({pass_valid, pass, cnt_exec, cnt_skip, status} !== exp_v) begin
      errors++;
      $display("FAIL basic_write: got %h expected %h", {pass_valid, pass, cnt_exec, cnt_skip, status}, exp_v);
    end
    drive_group(1'b0, 4'h0, 1'b0, 1'b0, 2'b11, {4'h1, 4'h0});
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    checks++;
    if ({pass_valid, pass, cnt_exec, cnt_skip, status} !== exp_v) begin
      errors++;
      $display("FAIL basic_eq_ne: got %h expected %h", {pass_valid, pass, cnt_exec, cnt_skip, status}, exp_v);
    end
    checks++;
    if ({pass_valid, pass, cnt_exec, cnt_skip} !== {2'b11, 2'b01, 16'd1, 16'd1}) begin
      errors++;
      $display("FAIL basic_const: got pv=%b p=%b exec=%0d skip=%0d expected pv=11 p=01 exec=1 skip=1",
               pass_valid, pass, cnt_exec, cnt_skip);
    end
  endtask

  task automatic test_sweep();
    logic [3:0] fv, c0, c1;
    for (int f = 0; f < 16; f++) begin
      fv = f[3:0];
      drive_group(1'b1, fv, 1'b0, 1'b0, 2'b00, 8'h00);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      checks++;
      if ({pass_valid, pass, cnt_exec, cnt_skip, status} !== exp_v) begin
        errors++;
        $display("FAIL sweep_write nzcv=%b: got %h expected %h", fv, {pass_valid, pass, cnt_exec, cnt_skip, status}, exp_v);
      end
      for (int c = 0; c < 16; c += 2) begin
        c0 = 4'(c); c1 = 4'(c + 1);
        drive_group(1'b0, 4'h0, 1'b0, 1'b0, 2'b11, {c1, c0});
        @(posedge clk); #1;
        exp_v = exp_q.pop_front();
        checks++;
        if ({pass_valid, pass, cnt_exec, cnt_skip, status} !== exp_v) begin
          errors++;
          $display("FAIL sweep nzcv=%b codes=%h,%h: got %h expected %h", fv, c0, c1,
                   {pass_valid, pass, cnt_exec, cnt_skip, status}, exp_v);
        end
      end
    end
  endtask

  task automatic test_same_cycle_write();
    logic exp_rdy;
`ifdef COND_BYPASS_EN
    exp_rdy = 1'b1;
`else
    exp_rdy = 1'b0;
`endif
    drive_group(1'b1, 4'b0000, 1'b0, 1'b0, 2'b00, 8'h00);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    checks++;
    if ({pass_valid, pass, cnt_exec, cnt_skip, status} !== exp_v) begin
      errors++;
      $display("FAIL samecyc_clear: got %h expected %h", {pass_valid, pass, cnt_exec, cnt_skip, status}, exp_v);
    end
    drive_group(1'b1, 4'b0100, 1'b0, 1'b0, 2'b01, 8'h00);
    #1;
    checks++;
    if (cond_ready !== exp_rdy) begin
      errors++;
      $display("FAIL samecyc_ready: got %b expected %b", cond_ready, exp_rdy);
    end
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    checks++;
    if ({pass_valid, pass, cnt_exec, cnt_skip, status} !== exp_v) begin
      errors++;
      $display("FAIL samecyc_first: got %h expected %h", {pass_valid, pass, cnt_exec, cnt_skip, status}, exp_v);
    end
    drive_group(1'b0, 4'h0, 1'b0, 1'b0, 2'b01, 8'h00);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    checks++;
    if ({pass_valid, pass, cnt_exec, cnt_skip, status} !== exp_v) begin
      errors++;
      $display("FAIL samecyc_held: got %h expected %h", {pass_valid, pass, cnt_exec, cnt_skip, status}, exp_v);
    end
    checks++;
    if ({pass_valid[0], pass[0]} !== 2'b11) begin
      errors++;
      $display("FAIL samecyc_eq: got pv0=%b p0=%b expected 1 1", pass_valid[0], pass[0]);
    end
  endtask

  task automatic test_flush();
    int e0, s0;
    drive_group(1'b0, 4'h0, 1'b0, 1'b0, 2'b11, 8'hEE);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    checks++;
    if ({pass_valid, pass, cnt_exec, cnt_skip, status} !== exp_v) begin
      errors++;
      $display("FAIL flush_pre: got %h expected %h", {pass_valid, pass, cnt_exec, cnt_skip, status}, exp_v);
    end
    e0 = int'(cnt_exec); s0 = int'(cnt_skip);
    drive_group(1'b0, 4'h0, 1'b1, 1'b0, 2'b11, 8'hEE);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    checks++;
    if ({pass_valid, pass, cnt_exec, cnt_skip, status} !== exp_v) begin
      errors++;
      $display("FAIL flush_drop: got %h expected %h", {pass_valid, pass, cnt_exec, cnt_skip, status}, exp_v);
    end
    checks++;
    if (pass_valid !== 2'b00 || int'(cnt_exec) != e0 || int'(cnt_skip) != s0) begin
      errors++;
      $display("FAIL flush_hold: got pv=%b exec=%0d skip=%0d expected pv=00 exec=%0d skip=%0d",
               pass_valid, cnt_exec, cnt_skip, e0, s0);
    end
    drive_group(1'b1, 4'b1011, 1'b1, 1'b0, 2'b11, 8'hE0);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    checks++;
    if ({pass_valid, pass, cnt_exec, cnt_skip, status} !== exp_v) begin
      errors++;
      $display("FAIL flush_write: got %h expected %h", {pass_valid, pass, cnt_exec, cnt_skip, status}, exp_v);
    end
  endtask

  task automatic test_saturation();
    drive_group(1'b0, 4'h0, 1'b0, 1'b1, 2'b00, 8'h00);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    checks++;
    if ({pass_valid, pass, cnt_exec, cnt_skip, status} !== exp_v) begin
      errors++;
      $display("FAIL sat_clear: got %h expected %h", {pass_valid, pass, cnt_exec, cnt_skip, status}, exp_v);
    end
    for (int k = 0; k < 32767; k++) begin
      drive_group(1'b0, 4'h0, 1'b0, 1'b0, 2'b11, 8'hEE);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      checks++;
      if ({pass_valid, pass, cnt_exec, cnt_skip, status} !== exp_v) begin
        errors++;
        $display("FAIL sat_fill k=%0d: got %h expected %h", k, {pass_valid, pass, cnt_exec, cnt_skip, status}, exp_v);
      end
    end
    checks++;
    if (cnt_exec !== 16'hFFFE || cnt_skip !== 16'h0000) begin
      errors++;
      $display("FAIL sat_preload: got exec=%h skip=%h expected exec=fffe skip=0000", cnt_exec, cnt_skip);
    end
    for (int k = 0; k < 3; k++) begin
      drive_group(1'b0, 4'h0, 1'b0, 1'b0, 2'b11, 8'hEE);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      checks++;
      if ({pass_valid, pass, cnt_exec, cnt_skip, status} !== exp_v) begin
        errors++;
        $display("FAIL sat_top k=%0d: got %h expected %h", k, {pass_valid, pass, cnt_exec, cnt_skip, status}, exp_v);
      end
      checks++;
      if (cnt_exec !== 16'hFFFF) begin
        errors++;
        $display("FAIL sat_hold k=%0d: got exec=%h expected ffff", k, cnt_exec);
      end
    end
    drive_group(1'b0, 4'h0, 1'b0, 1'b1, 2'b11, 8'hFE);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    checks++;
    if ({pass_valid, pass, cnt_exec, cnt_skip, status} !== exp_v) begin
      errors++;
      $display("FAIL sat_clr_accept: got %h expected %h", {pass_valid, pass, cnt_exec, cnt_skip, status}, exp_v);
    end
    checks++;
    if (cnt_exec !== 16'h0 || cnt_skip !== 16'h0) begin
      errors++;
      $display("FAIL sat_clr_wins: got exec=%h skip=%h expected 0000 0000", cnt_exec, cnt_skip);
    end
  endtask

  task automatic test_async_reset();
    drive_group(1'b1, 4'b1010, 1'b0, 1'b0, 2'b00, 8'h00);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    drive_group(1'b0, 4'h0, 1'b0, 1'b0, 2'b11, 8'hEE);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    checks++;
    if ({pass_valid, pass, cnt_exec, cnt_skip, status} !== exp_v) begin
      errors++;
      $display("FAIL areset_pre: got %h expected %h", {pass_valid, pass, cnt_exec, cnt_skip, status}, exp_v);
    end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pass_valid, pass, cnt_exec, cnt_skip, status} !== 40'h0) begin
      errors++;
      $display("FAIL areset_clear: got %h expected %h", {pass_valid, pass, cnt_exec, cnt_skip, status}, 40'h0);
    end
    mflags = 4'h0; mexec = 0; mskip = 0; exp_q.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    drive_group(1'b0, 4'h0, 1'b0, 1'b0, 2'b11, 8'hEE);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    checks++;
    if ({pass_valid, pass, cnt_exec, cnt_skip, status} !== exp_v) begin
      errors++;
      $display("FAIL areset_first: got %h expected %h", {pass_valid, pass, cnt_exec, cnt_skip, status}, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    logic       we, fl, clr;
    logic [3:0] fin;
    logic [1:0] vld;
    logic [7:0] cd;
    for (int k = 0; k < 200; k++) begin
      we  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 6) == 0);
      clr = ($urandom_range(0, 19) == 0);
      fin = 4'($urandom_range(0, 15));
      vld = 2'($urandom_range(0, 3));
      cd  = 8'($urandom_range(0, 255));
      drive_group(we, fin, fl, clr, vld, cd);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      checks++;
      if ({pass_valid, pass, cnt_exec, cnt_skip, status} !== exp_v) begin
        errors++;
        $display("FAIL b2b k=%0d: got %h expected %h", k, {pass_valid, pass, cnt_exec, cnt_skip, status}, exp_v);
      end
    end
    drive_group(1'b0, 4'h0, 1'b0, 1'b0, 2'b00, 8'h00);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    checks++;
    if ({pass_valid, pass, cnt_exec, cnt_skip, status} !== exp_v) begin
      errors++;
      $display("FAIL b2b_idle: got %h expected %h", {pass_valid, pass, cnt_exec, cnt_skip, status}, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_same_cycle_write();
    test_flush();
    test_saturation();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/status_cond_unit.md
# status_cond_unit

Owns the processor's NZCV status register and evaluates the 4-bit condition field for up to LANES instructions per cycle, producing registered pass/skip results for the execute stage. The ALU writes flags on S-bit instructions, and conditions are resolved against the current flags. A valid/ready handshake and a flush input keep the unit in step with pipeline stalls and branch squashes. Saturating executed/skipped counters feed the performance monitor.

## Interface
- LANES, 2, conditions evaluated per cycle; lane 0 is the oldest instruction.
- CNT_W, 16, width of each performance counter.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flag_we  in  1  ALU status write strobe (S-bit instruction in EX).
- flag_in  in  4  new flags: [3]=N, [2]=Z, [1]=C, [0]=V.
- flush  in  1  squash pending results.
- cond_valid  in  LANES  per-lane request.
- cond  in  4*LANES  condition field; lane i uses cond[4i+3:4i].
- cond_ready  out  1  unit accepts requests this cycle.
- pass_valid  out  LANES  result valid, one per lane.
- pass  out  LANES  1 = execute, 0 = skip.
- status  out  4  current NZCV register.
- cnt_clr  in  1  synchronous clear of both counters.
- cnt_exec  out  CNT_W  count of accepted lanes that passed.
- cnt_skip  out  CNT_W  count of accepted lanes that failed.

## Operation
- Condition codes: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 NV 0.
- Status register: loaded with flag_in on any clock edge where flag_we=1, whatever the state of flush or cond_valid.
- Accept: a lane is accepted when cond_valid[i] and cond_ready are both 1 and flush is 0.
- Result: on the next edge, pass_valid[i] is set to the accept value and pass[i] to the evaluated condition. A lane that is not accepted gives pass_valid[i]=0 and pass[i]=0.
- Flush: pass_valid goes to all zero on the next edge. Requests presented in the flush cycle are dropped and not counted.
- Counters: on each edge, cnt_exec increases by the number of accepted passing lanes and cnt_skip by the number of accepted failing lanes. Both saturate at all-ones without wrapping. When cnt_clr=1 both go to 0, and clear wins over a same-cycle increment.
- Lanes are independent. All lanes in a cycle see the same flag source.

## Timing
- Reset values: status=0000, pass_valid=0, pass=0, cnt_exec=0, cnt_skip=0. cond_ready resets to 1.
- Latency is 1 cycle from accept to pass_valid, and a new group can be accepted every cycle.
- Which flags are used depends on COND_BYPASS_EN (see Configuration).
- Reset asserted mid-operation clears all state immediately, with no clock needed. After deassertion the first accept can occur on the first edge.
- When flag_we, flush and cond_valid are all high together, the flags are written and the requests are dropped.
- Counters saturate independently. If one lane pushes a counter to all-ones and another lane increments it in the same cycle, the counter holds at all-ones.

## Configuration
- COND_BYPASS_EN defined:
  - Conditions presented while flag_we=1 are evaluated against flag_in, so the write is forwarded within the same cycle.
  - cond_ready is tied to 1.
- COND_BYPASS_EN undefined:
  - Conditions are always evaluated against the status register.
  - cond_ready = !flag_we (combinational), so the requester holds its request for one cycle and it is evaluated against the updated register.
  - Single-cycle throughput is lost only in flag-write cycles.

## Test plan
- Reset, then write flags NZCV=0100 and present EQ on lane 0 and NE on lane 1 in the following cycle -> next cycle pass_valid=11, pass=01, cnt_exec=1, cnt_skip=1.
- Sweep all 16 codes against all 16 NZCV values -> pass matches the table, including LS: C=1,Z=0 gives 0 and C=0,Z=0 gives 1; NV always 0.
- Same-cycle write: status=0000, flag_we=1 with flag_in=0100, lane 0 EQ:
  - with COND_BYPASS_EN -> pass[0]=1 on the next cycle;
  - without -> cond_ready=0 that cycle, the request is held, and pass[0]=1 one cycle later.
- flush=1 together with cond_valid=11 while the previous results are valid -> pass_valid=00 on the next edge and both counters unchanged.
- Preload cnt_exec to 0xFFFE, then two passing lanes AL,AL -> cnt_exec=0xFFFF and it stays there on further passes. cnt_clr with a same-cycle accept -> 0.
- Assert rst_n low asynchronously between edges while pass_valid=11 -> pass_valid=00, status=0000 and counters 0 without waiting for a clock edge.
